mult_div_unit: RTL and testbench

Multi-cycle signed multiply/divide responder for the multicycle MIPS datapath. The control unit issues a one-cycle `start` from its mult/div state with the operation and the A/B register values. The control unit then waits for `done`. The block computes a 64-bit signed product or a signed quotient/remainder and holds the results in its HI/LO registers. It reports division by zero so the control unit can branch to its divide-by-zero exception state.

---
 rtl/mult_div_unit.sv | 177 +++++++++++++++++
 tb/tb_mult_div_unit.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - multi-cycle signed multiply/divide unit with HI/LO result registers
//
// Computes a signed 2*WIDTH product (shift-add) or a signed quotient/remainder
// (restoring division) over WIDTH cycles, working on operand magnitudes and
// fixing the result signs on the final iteration.
//
// Ports:
//   clock     - clock, all state updates on the rising edge
//   reset     - synchronous active-high reset
//   start     - request pulse, accepted only while idle
//   op        - 0 = mult, 1 = div, sampled with start
//   a_in      - multiplicand / dividend, sampled with start
//   b_in      - multiplier / divisor, sampled with start
//   busy      - high while an operation is running or completing
//   done      - one-cycle completion pulse
//   div_zero  - one-cycle pulse alongside done when a div had a zero divisor
//   hi        - product upper half, or remainder
//   lo        - product lower half, or quotient

module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               op_q, op_d;
    logic               neg_q, neg_d;          // quotient / product sign
    logic               rem_neg_q, rem_neg_d;  // remainder follows dividend sign
    logic [WIDTH-1:0]   opnd_q, opnd_d;        // multiplicand or divisor magnitude
    // Shared work register {upper[WIDTH:0], lower[WIDTH-1:0]}:
    //   mult: upper = running partial product, lower = multiplier being shifted out
    //   div:  upper = partial remainder,       lower = dividend shifting into quotient
    logic [2*WIDTH:0]   work_q, work_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               div_zero_q, div_zero_d;

    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     upper;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH+1:0]   div_diff;
    logic               div_ok;
    logic [2*WIDTH:0]   iter_next;
    logic [2*WIDTH-1:0] prod_mag, prod_signed;
    logic [WIDTH-1:0]   quot_mag, rem_mag;

    // Magnitude of the most negative value is representable as unsigned WIDTH bits.
    assign a_mag = a_in[WIDTH-1] ? (~a_in + 1'b1) : a_in;
    assign b_mag = b_in[WIDTH-1] ? (~b_in + 1'b1) : b_in;

    assign upper     = work_q[2*WIDTH:WIDTH];
    assign mul_sum   = work_q[0] ? (upper + {1'b0, opnd_q}) : upper;
    assign div_shift = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
    // One extra bit so the trial subtraction's sign is unambiguous.
    assign div_diff  = {1'b0, div_shift} - {2'b00, opnd_q};
    assign div_ok    = ~div_diff[WIDTH+1];

    always_comb begin
        if (op_q) begin
            iter_next = {(div_ok ? div_diff[WIDTH:0] : div_shift),
                         work_q[WIDTH-2:0], div_ok};
        end else begin
            iter_next = {1'b0, mul_sum, work_q[WIDTH-1:1]};
        end
    end

    assign prod_mag    = iter_next[2*WIDTH-1:0];
    assign prod_signed = neg_q ? (~prod_mag + 1'b1) : prod_mag;
    assign quot_mag    = iter_next[WIDTH-1:0];
    assign rem_mag     = iter_next[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        neg_d      = neg_q;
        rem_neg_d  = rem_neg_q;
        opnd_d     = opnd_q;
        work_d     = work_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        div_zero_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d      = op;
                    neg_d     = a_in[WIDTH-1] ^ b_in[WIDTH-1];
                    rem_neg_d = a_in[WIDTH-1];
                    cnt_d     = '0;
                    opnd_d    = op ? b_mag : a_mag;
                    work_d    = {{(WIDTH+1){1'b0}}, (op ? a_mag : b_mag)};
                    if (op && (b_in == '0)) begin
                        state_d    = S_DONE;
                        div_zero_d = 1'b1;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                work_d = iter_next;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                    if (op_q) begin
                        lo_d = neg_q ? (~quot_mag + 1'b1) : quot_mag;
                        hi_d = rem_neg_q ? (~rem_mag + 1'b1) : rem_mag;
                    end else begin
                        hi_d = prod_signed[2*WIDTH-1:WIDTH];
                        lo_d = prod_signed[WIDTH-1:0];
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            op_q       <= 1'b0;
            neg_q      <= 1'b0;
            rem_neg_q  <= 1'b0;
            opnd_q     <= '0;
            work_q     <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            neg_q      <= neg_d;
            rem_neg_q  <= rem_neg_d;
            opnd_q     <= opnd_d;
            work_q     <= work_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign div_zero = div_zero_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - directed self-checking bench for mult_div_unit
module tb_mult_div_unit;

    logic        clock;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks;
    int errors;

    mult_div_unit #(.WIDTH(32)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a_in     (a_in),
        .b_in     (b_in),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Called at the start of cycle k (just after a rising edge). Returns the
    // cycle offset at which done was seen, the outputs in that cycle, the number
    // of cycles k+1..done where busy was low, and busy in the following cycle.
    // Leaves the caller at the start of the cycle after done.
    task automatic run_op(input logic o, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic [31:0] h, output logic [31:0] l,
                          output logic dz, output int busy_low, output logic busy_after);
        int c;
        logic found;
        start = 1'b1; op = o; a_in = a; b_in = b;
        @(posedge clock); #1;
        start = 1'b0;
        c = 1; found = 1'b0; busy_low = 0;
        while (c < 40 && !found) begin
            @(negedge clock);
            if (!busy) busy_low++;
            if (done) found = 1'b1;
            else begin
                @(posedge clock); #1;
                c++;
            end
        end
        lat = found ? c : 99;
        h = hi; l = lo; dz = div_zero;
        @(posedge clock); #1;
        @(negedge clock);
        busy_after = busy;
        @(posedge clock); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; op = 1'b0; a_in = '0; b_in = '0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || div_zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: busy=%b done=%b div_zero=%b, want 0 0 0", busy, done, div_zero);
        end
        checks++;
        if (hi !== 32'h0 || lo !== 32'h0) begin
            errors++;
            $display("FAIL reset_hilo: hi=%h lo=%h, want 0 0", hi, lo);
        end
        @(posedge clock); #1;
    endtask

    task automatic test_mult();
        int lat, bl; logic [31:0] h, l; logic dz, ba;
        run_op(1'b0, 32'd7, 32'hFFFF_FFFD, lat, h, l, dz, bl, ba);
        checks++;
        if (lat !== 33) begin errors++; $display("FAIL mult_latency: got %0d, want 33", lat); end
        checks++;
        if (h !== 32'hFFFF_FFFF || l !== 32'hFFFF_FFEB) begin
            errors++; $display("FAIL mult_7x-3: hi=%h lo=%h, want ffffffff ffffffeb", h, l);
        end
        checks++;
        if (bl !== 0 || ba !== 1'b0) begin
            errors++; $display("FAIL mult_busy: low_cycles=%0d busy_after=%b, want 0 0", bl, ba);
        end
        checks++;
        if (dz !== 1'b0) begin errors++; $display("FAIL mult_divzero: got %b, want 0", dz); end

        run_op(1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, lat, h, l, dz, bl, ba);
        checks++;
        if (h !== 32'h3FFF_FFFF || l !== 32'h0000_0001) begin
            errors++; $display("FAIL mult_maxpos: hi=%h lo=%h, want 3fffffff 00000001", h, l);
        end
        run_op(1'b0, 32'hFFFF_FFFA, 32'hFFFF_FFFC, lat, h, l, dz, bl, ba);
        checks++;
        if (h !== 32'h0 || l !== 32'd24) begin
            errors++; $display("FAIL mult_negneg: hi=%h lo=%h, want 00000000 00000018", h, l);
        end
        run_op(1'b0, 32'h8000_0000, 32'h8000_0000, lat, h, l, dz, bl, ba);
        checks++;
        if (h !== 32'h4000_0000 || l !== 32'h0) begin
            errors++; $display("FAIL mult_minmin: hi=%h lo=%h, want 40000000 00000000", h, l);
        end
    endtask

    task automatic test_div();
        int lat, bl; logic [31:0] h, l; logic dz, ba;
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, lat, h, l, dz, bl, ba);
        checks++;
        if (lat !== 33) begin errors++; $display("FAIL div_latency: got %0d, want 33", lat); end
        checks++;
        if (l !== 32'hFFFF_FFFD || h !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL div_-7/2: hi=%h lo=%h, want ffffffff fffffffd", h, l);
        end
        run_op(1'b1, 32'd100, 32'hFFFF_FFF9, lat, h, l, dz, bl, ba);
        checks++;
        if (l !== 32'hFFFF_FFF2 || h !== 32'd2) begin
            errors++; $display("FAIL div_100/-7: hi=%h lo=%h, want 00000002 fffffff2", h, l);
        end
        run_op(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, lat, h, l, dz, bl, ba);
        checks++;
        if (l !== 32'd14 || h !== 32'hFFFF_FFFE) begin
            errors++; $display("FAIL div_-100/-7: hi=%h lo=%h, want fffffffe 0000000e", h, l);
        end
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, h, l, dz, bl, ba);
        checks++;
        if (l !== 32'h8000_0000 || h !== 32'h0 || dz !== 1'b0) begin
            errors++; $display("FAIL div_overflow: hi=%h lo=%h dz=%b, want 00000000 80000000 0", h, l, dz);
        end
    endtask

    task automatic test_div_zero();
        int lat, bl; logic [31:0] h, l; logic dz, ba;
        run_op(1'b0, 32'd5, 32'd5, lat, h, l, dz, bl, ba);
        checks++;
        if (l !== 32'd25 || h !== 32'd0) begin
            errors++; $display("FAIL dz_preload: hi=%h lo=%h, want 0 25", h, l);
        end
        run_op(1'b1, 32'd9, 32'd0, lat, h, l, dz, bl, ba);
        checks++;
        if (lat !== 1 || dz !== 1'b1) begin
            errors++; $display("FAIL dz_pulse: latency=%0d dz=%b, want 1 1", lat, dz);
        end
        checks++;
        if (h !== 32'd0 || l !== 32'd25) begin
            errors++; $display("FAIL dz_hold: hi=%h lo=%h, want 0 25", h, l);
        end
        checks++;
        if (ba !== 1'b0 || div_zero !== 1'b0) begin
            errors++; $display("FAIL dz_idle: busy=%b div_zero=%b, want 0 0", ba, div_zero);
        end
    endtask

    task automatic test_start_ignored();
        int c; logic found;
        start = 1'b1; op = 1'b1; a_in = 32'd100; b_in = 32'd7;
        @(posedge clock); #1;
        start = 1'b0;
        c = 1; found = 1'b0;
        while (c < 40 && !found) begin
            if (c == 5) begin start = 1'b1; op = 1'b0; a_in = 32'd3; b_in = 32'd3; end
            else start = 1'b0;
            @(negedge clock);
            if (done) found = 1'b1;
            else begin @(posedge clock); #1; c++; end
        end
        start = 1'b0;
        checks++;
        if (!found || c !== 33 || lo !== 32'd14 || hi !== 32'd2) begin
            errors++; $display("FAIL start_ignored: cycle=%0d hi=%h lo=%h, want 33 2 14", c, hi, lo);
        end
        @(posedge clock); #1;
        @(posedge clock); #1;
    endtask

    task automatic test_reset_midrun();
        int dcount;
        dcount = 0;
        start = 1'b1; op = 1'b0; a_in = 32'd11; b_in = 32'd13;
        @(posedge clock); #1;
        start = 1'b0;
        for (int i = 1; i < 10; i++) begin
            @(negedge clock);
            if (done) dcount++;
            @(posedge clock); #1;
        end
        reset = 1'b1; start = 1'b1;
        @(negedge clock);
        if (done) dcount++;
        @(posedge clock); #1;
        reset = 1'b0; start = 1'b0;
        @(negedge clock);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            errors++; $display("FAIL reset_midrun: busy=%b done=%b hi=%h lo=%h, want 0 0 0 0", busy, done, hi, lo);
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (done || busy) dcount++;
        end
        checks++;
        if (dcount !== 0) begin
            errors++; $display("FAIL reset_no_done: activity_cycles=%0d, want 0", dcount);
        end
        @(posedge clock); #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_start_ignored();
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
